// File: rtl/circuit_tester.sv
// circuit_tester: drives the two-flip-flop lab circuit through all 16 input vectors and checks Y/Z against a cycle-accurate model.
module circuit_tester #(
    parameter int HOLD = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       Y_IN,
    input  logic       Z_IN,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic [3:0] VEC,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] ERR_CNT,
    output logic [3:0] FIRST_FAIL,
    output logic       MISMATCH
);
    typedef enum logic [1:0] {sIdle, sInit, sRun, sDone} stateT;
    localparam logic [3:0] holdLast = 4'(HOLD - 1);
    stateT state;
    logic initCnt;
    logic [3:0] holdCnt;
    logic q1, q2;
    logic yExp, zExp, sampleNow, isMiss;
    logic [7:0] errNext;
    always_comb begin
        yExp = q1;
        zExp = ~((q2 | C) & (B | ~q1));
        sampleNow = (state == sRun) && (holdCnt == holdLast);
        isMiss = sampleNow && ((Y_IN != yExp) || (Z_IN != zExp));
        errNext = (isMiss && ERR_CNT != 8'hFF) ? ERR_CNT + 8'd1 : ERR_CNT;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= sIdle;
            initCnt <= 1'b0;
            holdCnt <= 4'd0;
            {A, B, C, D} <= 4'b0000;
            VEC <= 4'd0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            PASS <= 1'b0;
            ERR_CNT <= 8'd0;
            FIRST_FAIL <= 4'd0;
            MISMATCH <= 1'b0;
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else begin
            MISMATCH <= isMiss;
            if (state == sInit || state == sRun) begin
                q1 <= (A & C) | (B & D);
                q2 <= ~((q1 & D) & (A & C));
            end
            case (state)
                sIdle, sDone: if (START) begin
                    // 1010 forces both circuit flops to 1, matching the model load below
                    state <= sInit;
                    initCnt <= 1'b0;
                    {A, B, C, D} <= 4'b1010;
                    VEC <= 4'd0;
                    BUSY <= 1'b1;
                    DONE <= 1'b0;
                    PASS <= 1'b0;
                    ERR_CNT <= 8'd0;
                    FIRST_FAIL <= 4'd0;
                    q1 <= 1'b1;
                    q2 <= 1'b1;
                end
                sInit: begin
                    initCnt <= 1'b1;
                    if (initCnt) begin
                        state <= sRun;
                        holdCnt <= 4'd0;
                        VEC <= 4'd0;
                        {A, B, C, D} <= 4'b0000;
                    end
                end
                sRun: begin
                    ERR_CNT <= errNext;
                    if (isMiss && ERR_CNT == 8'd0) FIRST_FAIL <= VEC;
                    if (sampleNow) begin
                        holdCnt <= 4'd0;
                        if (VEC == 4'hF) begin
                            state <= sDone;
                            {A, B, C, D} <= 4'b0000;
                            BUSY <= 1'b0;
                            DONE <= 1'b1;
                            PASS <= (errNext == 8'd0);
                        end else begin
                            VEC <= VEC + 4'd1;
                            {A, B, C, D} <= VEC + 4'd1;
                        end
                    end else begin
                        holdCnt <= holdCnt + 4'd1;
                    end
                end
                default: state <= sIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_circuit_tester.sv
// tb_circuit_tester: directed bench pairing circuit_tester with a stand-in lab circuit and optional stuck-at-0 outputs.
`timescale 1ns/1ps
module tb_circuit_tester;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic start = 1'b0;
    logic yIn, zIn, a, b, c, d, busy, done, pass, mismatch;
    logic [3:0] vec, firstFail;
    logic [7:0] errCnt;
    logic cq1 = 1'b0;
    logic cq2 = 1'b0;
    logic yForce = 1'b0;
    logic zForce = 1'b0;
    int checks = 0;
    int failures = 0;
    int misCount = 0;
    int cycles = 0;
    logic [15:0] misMask = 16'h0;

    always #100 clk = ~clk;

    circuit_tester #(.HOLD(4)) dut (
        .CLK(clk), .RST_N(rstN), .START(start), .Y_IN(yIn), .Z_IN(zIn),
        .A(a), .B(b), .C(c), .D(d), .VEC(vec), .BUSY(busy), .DONE(done),
        .PASS(pass), .ERR_CNT(errCnt), .FIRST_FAIL(firstFail), .MISMATCH(mismatch)
    );

    // stand-in for the lab circuit: no reset, outputs optionally stuck at 0
    always @(posedge clk) begin
        cq1 <= (a & c) | (b & d);
        cq2 <= ~((cq1 & d) & (a & c));
    end
    assign yIn = yForce ? 1'b0 : cq1;
    assign zIn = zForce ? 1'b0 : ~((cq2 | c) & (b | ~cq1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic runToDone(input int pulseAt);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cycles = 1;
        misCount = 0;
        misMask = 16'h0;
        check("init_busy", busy, 1);
        check("init_abcd", {a, b, c, d}, 4'hA);
        check("init_err_clr", errCnt, 0);
        check("init_ff_clr", firstFail, 0);
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
            start = (cycles == pulseAt);
            if (mismatch) begin
                misCount++;
                misMask[vec - 4'd1] = 1'b1;
            end
            if (cycles == 2) check("init2_abcd", {a, b, c, d}, 4'hA);
            if (cycles == 3) check("run0_vec_abcd", {vec, a, b, c, d}, 8'h00);
            if (cycles == 23) check("run5_vec_abcd", {vec, a, b, c, d}, 8'h55);
        end
        start = 1'b0;
        check("latency", cycles, 67);
        check("done_flag", done, 1);
        check("done_busy", busy, 0);
        check("done_abcd", {a, b, c, d}, 4'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk) start = ~start;
        start = 1'b0;
        check("rst_busy_done_pass_mis", {busy, done, pass, mismatch}, 4'h0);
        check("rst_err", errCnt, 0);
        check("rst_ff", firstFail, 0);
        check("rst_abcd_vec", {a, b, c, d, vec}, 8'h00);
        @(negedge clk) rstN = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        runToDone(0);
        check("good_pass", pass, 1);
        check("good_err", errCnt, 0);
        check("good_ff", firstFail, 0);
        check("good_mis_count", misCount, 0);

        zForce = 1'b1;
        runToDone(0);
        zForce = 1'b0;
        check("z0_err", errCnt, 2);
        check("z0_ff", firstFail, 4'hA);
        check("z0_pass", pass, 0);
        check("z0_mis_count", misCount, 2);
        check("z0_mis_vecs", misMask, 16'h0C00);

        yForce = 1'b1;
        runToDone(0);
        yForce = 1'b0;
        check("y0_err", errCnt, 7);
        check("y0_ff", firstFail, 4'h5);
        check("y0_pass", pass, 0);
        check("y0_mis_count", misCount, 7);

        runToDone(30);
        check("restart_pass", pass, 1);
        check("restart_err", errCnt, 0);
        repeat (5) @(negedge clk);
        check("done_stable", {done, pass, busy}, 3'b110);

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cycles = 0;
        while (vec != 4'd7 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("midrun_vec7", {busy, vec}, 5'h17);
        #20 rstN = 1'b0;
        #1;
        check("abort_status", {busy, done, pass, mismatch}, 4'h0);
        check("abort_abcd_vec", {a, b, c, d, vec}, 8'h00);
        check("abort_err_ff", {errCnt, firstFail}, 12'h000);
        @(negedge clk) rstN = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_idle", {busy, done}, 2'b00);

        runToDone(0);
        check("after_abort_pass", pass, 1);
        check("after_abort_err", errCnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/circuit_tester.md
# circuit_tester

Self-checking stimulus driver for the two-flip-flop clocked lab circuit (inputs A, B, C, D; outputs Y, Z). It drives the circuit's inputs, runs a cycle-accurate internal model of the circuit, and compares the circuit's Y/Z against the model. It sits beside the circuit on the same CLK as the board-level and bench-level harness. It reports an error count, the first failing vector, and pass/done flags.

## Interface
- HOLD, 4: clock cycles each input vector is held; legal range 3..15.
- CLK  input  1  rising-edge clock, shared with the circuit under test
- RST_N  input  1  asynchronous active-low reset
- START  input  1  single-cycle pulse; begins a run when in IDLE or DONE
- Y_IN  input  1  circuit output Y
- Z_IN  input  1  circuit output Z
- A, B, C, D  output  1 each  drive circuit inputs; vector bits {A,B,C,D} = vec[3:0], A is the MSB
- VEC  output  4  index of the vector currently driven
- BUSY  output  1  high in INIT and RUN
- DONE  output  1  high in DONE
- PASS  output  1  valid when DONE; 1 iff ERR_CNT == 0
- ERR_CNT  output  8  mismatching vectors, saturating at 255
- FIRST_FAIL  output  4  VEC of the first mismatch; 0 if none
- MISMATCH  output  1  one-cycle pulse on each failing sample

## Operation
- FSM states: IDLE, INIT, RUN, DONE.
  - IDLE -> INIT on START.
  - INIT lasts exactly 2 cycles, then goes to RUN.
  - RUN lasts 16*HOLD cycles, then goes to DONE.
  - DONE -> INIT on START.
  - START is ignored in INIT and RUN.
- INIT:
  - Drives ABCD = 1010. This forces both circuit flip-flops to 1 regardless of their power-up value, because the circuit has no reset.
  - Model state is loaded to q1 = 1, q2 = 1.
  - ERR_CNT, FIRST_FAIL and PASS are cleared.
- RUN:
  - vec counts 0..15. Each value is held for HOLD cycles.
  - A hold counter counts 0..HOLD-1 and wraps. vec increments on the wrap.
- Model update, on every rising edge in INIT and RUN, using the currently driven vector:
  - q1 <= (A&C) | (B&D)
  - q2 <= ~((q1&D) & (A&C))
- Expected outputs, combinational from model state and the current vector:
  - Y_exp = q1
  - Z_exp = ~((q2|C) & (B|~q1))
- Compare on the last cycle of each hold window (hold counter == HOLD-1), at the rising edge ending that cycle.
  - Mismatch when (Y_IN != Y_exp) or (Z_IN != Z_exp).
  - At most one error is counted per vector.
- On mismatch:
  - ERR_CNT increments, saturating at 255.
  - FIRST_FAIL is captured only when ERR_CNT was 0.
  - MISMATCH pulses for the following cycle.
- DONE:
  - ABCD are held at 0000.
  - Results stay stable until the next START or reset.

## Timing
- Reset values (asynchronous, while RST_N = 0):
  - state = IDLE
  - ABCD = 0000, VEC = 0
  - BUSY = 0, DONE = 0, PASS = 0, MISMATCH = 0
  - ERR_CNT = 0, FIRST_FAIL = 0
  - q1 = q2 = 0
- Reset asserted mid-run aborts immediately to the values above. No partial result is retained.
- START sampled at edge t gives BUSY = 1 and ABCD = 1010 from t+1.
- RUN starts at t+3. DONE rises at t + 3 + 16*HOLD. Total latency with HOLD = 4 is 67 cycles.
- A, B, C, D, VEC and all status outputs are registered. There are no combinational paths from Y_IN or Z_IN to any output.
- The circuit under test has 15–20 ns gate delays and a worst-case Z path of about 75 ns. The bench clock period must be ≥ 200 ns.
- HOLD ≥ 3 guarantees at least 2 model/circuit updates per vector before sampling, so both flops have settled.
- With a correct circuit at sample time:
  - Y_exp = AC|BD
  - Z_exp = 1 only for vectors 1010 and 1011

## Test plan
- Reset: hold RST_N = 0 for 3 cycles with START toggling -> all outputs at reset values, state IDLE, ABCD = 0000.
- Correct circuit, HOLD = 4: pulse START -> ABCD = 1010 for 2 cycles, then vectors 0..15 at 4 cycles each. DONE = 1 at cycle 67; PASS = 1, ERR_CNT = 0, FIRST_FAIL = 0, MISMATCH never pulses.
- Z_IN forced to 0 -> ERR_CNT = 2, FIRST_FAIL = 0xA, PASS = 0, MISMATCH pulses at vectors 0xA and 0xB.
- Y_IN forced to 0 -> ERR_CNT = 7 (vectors 5, 7, A, B, D, E, F), FIRST_FAIL = 0x5.
- START pulsed during RUN -> ignored, and the run completes on schedule. START pulsed in DONE -> new run, and ERR_CNT/FIRST_FAIL clear in INIT.
- RST_N pulsed low at VEC = 7 -> immediate return to reset values. A following START gives a full, correct run with PASS = 1.
